// File: rtl/qspi_flash_reader_if.sv
// Request/response port of qspi_flash_reader.
//   req    : read request (master -> slave)
//   addr   : 24-bit byte address, bits [1:0] ignored (master -> slave)
//   gnt    : request accepted in this cycle (slave -> master)
//   rvalid : one-cycle pulse, rdata carries the read word (slave -> master)
//   rdata  : 32-bit read word, held until the next rvalid (slave -> master)
interface qspi_flash_reader_if;
   localparam int unsigned AddrW = 24;
   localparam int unsigned DataW = 32;

   logic             req;
   logic [AddrW-1:0] addr;
   logic             gnt;
   logic             rvalid;
   logic [DataW-1:0] rdata;

   modport master (output req, output addr, input gnt, input rvalid, input rdata);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/qspi_flash_reader.sv
// Read-only quad-SPI flash master. Every accepted request runs one Fast Read
// Quad Output (0x6B) transaction and returns a single 32-bit word.
//   clk_i           : system clock
//   rst_ni          : asynchronous active-low reset
//   bus             : req/addr/gnt/rvalid/rdata request port (slave side)
//   flash_sck_o     : SPI clock, mode 0 (idles low)
//   flash_ce_n_o    : chip enable, active low
//   flash_dout_o    : pad output data d3..d0
//   flash_dout_en_o : pad output enables, 1 = drive
//   flash_din_i     : pad input data d3..d0
module qspi_flash_reader #(
   parameter int unsigned ClkDiv      = 1,
   parameter int unsigned DummyCycles = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   qspi_flash_reader_if.slave    bus,
   output logic                  flash_sck_o,
   output logic                  flash_ce_n_o,
   output logic [3:0]            flash_dout_o,
   output logic [3:0]            flash_dout_en_o,
   input  logic [3:0]            flash_din_i
);

   localparam int unsigned DivW        = 8;
   localparam int unsigned CntW        = 6;
   localparam int unsigned GapW        = 9;
   localparam int unsigned CmdBits     = 8;
   localparam int unsigned AddrBits    = 24;
   localparam int unsigned DataPeriods = 8;
   localparam int unsigned NumPeriods  = CmdBits + AddrBits + DummyCycles + DataPeriods;

   localparam logic [7:0]      Opcode    = 8'h6B;
   localparam logic [23:0]     AddrMask  = 24'hFF_FFFC;
   localparam logic [3:0]      PadIdle   = 4'b1100;
   localparam logic [3:0]      EnCmd     = 4'b1101;
   localparam logic [3:0]      EnOff     = 4'b0000;
   localparam logic [DivW-1:0] DivLast   = DivW'(ClkDiv - 1);
   localparam logic [GapW-1:0] GapLast   = GapW'(2 * ClkDiv - 1);
   localparam logic [CntW-1:0] CmdLast   = CntW'(CmdBits - 1);
   localparam logic [CntW-1:0] AddrLast  = CntW'(CmdBits + AddrBits - 1);
   localparam logic [CntW-1:0] DummyLast = CntW'(CmdBits + AddrBits + DummyCycles - 1);
   localparam logic [CntW-1:0] DataLast  = CntW'(NumPeriods - 1);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      DATA,
      GAP
   } state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [CntW-1:0]   bit_q, bit_d;
   logic [GapW-1:0]   gap_q, gap_d;
   logic [31:0]       shift_q, shift_d;
   logic [31:0]       rx_q, rx_d;
   logic              sck_q, sck_d;
   logic              ce_n_q, ce_n_d;
   logic [3:0]        dout_q, dout_d;
   logic [3:0]        dout_en_q, dout_en_d;
   logic              rvalid_q, rvalid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              gnt_c;

   logic              active;
   logic              tick;
   logic              sck_rise;
   logic              sck_fall;

   // SCK half-period boundaries; a rising edge samples, a falling edge shifts
   assign active   = (state_q == CMD) || (state_q == ADDR) ||
                     (state_q == DUMMY) || (state_q == DATA);
   assign tick     = (div_q == DivLast);
   assign sck_rise = tick & ~sck_q;
   assign sck_fall = tick & sck_q;

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         gap_q     <= '0;
         shift_q   <= '0;
         rx_q      <= '0;
         sck_q     <= 1'b0;
         ce_n_q    <= 1'b1;
         dout_q    <= PadIdle;
         dout_en_q <= EnOff;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         gap_q     <= gap_d;
         shift_q   <= shift_d;
         rx_q      <= rx_d;
         sck_q     <= sck_d;
         ce_n_q    <= ce_n_d;
         dout_q    <= dout_d;
         dout_en_q <= dout_en_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      gap_d     = gap_q;
      shift_d   = shift_q;
      rx_d      = rx_q;
      sck_d     = sck_q;
      ce_n_d    = ce_n_q;
      dout_d    = dout_q;
      dout_en_d = dout_en_q;
      rvalid_d  = 1'b0;
      rdata_d   = rdata_q;
      gnt_c     = 1'b0;

      // SCK generator, shared by all states that keep CE low
      if (active) begin
         div_d = tick ? '0 : div_q + DivW'(1);
         if (tick) begin
            sck_d = ~sck_q;
         end
         if (sck_fall) begin
            bit_d = bit_q + CntW'(1);
         end
      end

      unique case (state_q)
         IDLE: begin
            // Reset gates the grant because the state register sits in IDLE
            gnt_c = bus.req & rst_ni;
            if (bus.req) begin
               state_d   = CMD;
               shift_d   = {Opcode, bus.addr & AddrMask};
               rx_d      = '0;
               div_d     = '0;
               bit_d     = '0;
               sck_d     = 1'b0;
               ce_n_d    = 1'b0;
               dout_en_d = EnCmd;
               dout_d    = {PadIdle[3:1], Opcode[7]};
            end
         end

         CMD: begin
            if (sck_fall) begin
               // Rotate so the next bit to send is always at the MSB
               shift_d   = {shift_q[30:0], shift_q[31]};
               dout_d[0] = shift_q[30];
               if (bit_q == CmdLast) begin
                  state_d = ADDR;
               end
            end
         end

         ADDR: begin
            if (sck_fall) begin
               if (bit_q == AddrLast) begin
                  state_d   = (DummyCycles == 0) ? DATA : DUMMY;
                  dout_en_d = EnOff;
                  dout_d    = PadIdle;
               end else begin
                  shift_d   = {shift_q[30:0], shift_q[31]};
                  dout_d[0] = shift_q[30];
               end
            end
         end

         DUMMY: begin
            if (sck_fall && (bit_q == DummyLast)) begin
               state_d = DATA;
            end
         end

         DATA: begin
            if (sck_rise) begin
               rx_d = {rx_q[27:0], flash_din_i};
            end
            if (sck_fall && (bit_q == DataLast)) begin
               // Nibbles arrive byte0-high first; byte n lands in rdata[8n+7:8n]
               state_d  = GAP;
               ce_n_d   = 1'b1;
               gap_d    = '0;
               rvalid_d = 1'b1;
               rdata_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
            end
         end

         GAP: begin
            // CE stays high for 2*ClkDiv cycles before the next grant
            if (gap_q == GapLast) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + GapW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.gnt         = gnt_c;
   assign bus.rvalid      = rvalid_q;
   assign bus.rdata       = rdata_q;
   assign flash_sck_o     = sck_q;
   assign flash_ce_n_o    = ce_n_q;
   assign flash_dout_o    = dout_q;
   assign flash_dout_en_o = dout_en_q;

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Bench for qspi_flash_reader: random reads against a flash device model,
// with expected words queued at grant time and checked when rvalid appears.
module tb_qspi_flash_reader;

   localparam int unsigned D     = 3;
   localparam int unsigned DUMMY = 8;
   localparam int unsigned N     = 40 + DUMMY;
   localparam int unsigned LAT   = 1 + 2 * N * D;
   localparam int unsigned GAPC  = 2 * D;

   typedef struct {
      logic [23:0] addr;
      logic [31:0] word;
      int unsigned due;
   } exp_t;

   logic        clk    = 1'b0;
   logic        rst_ni = 1'b0;
   logic        sck;
   logic        ce_n;
   logic [3:0]  dout;
   logic [3:0]  dout_en;
   logic [3:0]  din    = 4'h0;
   int unsigned cyc    = 0;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   exp_t        exp_q[$];
   logic [7:0]  mem [int];

   qspi_flash_reader_if bus ();

   qspi_flash_reader #(
      .ClkDiv      (D),
      .DummyCycles (DUMMY)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .bus             (bus),
      .flash_sck_o     (sck),
      .flash_ce_n_o    (ce_n),
      .flash_dout_o    (dout),
      .flash_dout_en_o (dout_en),
      .flash_din_i     (din)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Flash array contents: a few fixed bytes, everything else a hash of the address
   function automatic logic [7:0] flash_byte(input logic [23:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return 8'(a * 24'd167) ^ a[15:8] ^ 8'h5A;
   endfunction

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   int unsigned r;
   int unsigned run;
   int unsigned hi_run;
   int unsigned next_free;
   int unsigned j;
   logic [31:0] ca;
   logic [23:0] flash_addr;
   logic [31:0] last_rdata;
   logic [7:0]  b;
   logic        p_sck, p_ce_n;
   logic [3:0]  p_dout, p_dout_en;
   exp_t        cur;

   always @(negedge clk) begin
      if (!rst_ni) begin
         chk(ce_n == 1'b1, "rst_ce_n", 32'(ce_n), 32'd1);
         chk(sck == 1'b0, "rst_sck", 32'(sck), 32'd0);
         chk(dout_en == 4'b0000, "rst_dout_en", 32'(dout_en), 32'd0);
         chk(dout == 4'b1100, "rst_dout", 32'(dout), 32'hC);
         chk(bus.gnt == 1'b0, "rst_gnt", 32'(bus.gnt), 32'd0);
         chk(bus.rvalid == 1'b0, "rst_rvalid", 32'(bus.rvalid), 32'd0);
         chk(bus.rdata == 32'h0, "rst_rdata", bus.rdata, 32'h0);
         r          = 0;
         run        = 0;
         hi_run     = GAPC;
         next_free  = 0;
         last_rdata = 32'h0;
         din        = 4'($urandom);
      end else begin
         // Grant is only allowed while the model is idle
         chk(bus.gnt == (bus.req && (cyc >= next_free)), "gnt",
             32'(bus.gnt), 32'(bus.req && (cyc >= next_free)));
         if (bus.gnt && bus.req) next_free = cyc + LAT + GAPC;

         // Response scoreboard
         if (bus.rvalid) begin
            chk(exp_q.size() != 0, "rvalid_expected", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               chk(bus.rdata == cur.word, "rdata", bus.rdata, cur.word);
               chk(cyc == cur.due, "rvalid_cycle", 32'(cyc), 32'(cur.due));
            end
            last_rdata = bus.rdata;
         end else begin
            chk(bus.rdata == last_rdata, "rdata_hold", bus.rdata, last_rdata);
            if (exp_q.size() != 0) begin
               chk(cyc <= exp_q[0].due, "rvalid_overdue", 32'(cyc), 32'(exp_q[0].due));
               if (cyc > exp_q[0].due) void'(exp_q.pop_front());
            end
         end

         // Flash device model and pin discipline
         if (ce_n) begin
            chk((sck == 1'b0) && (dout_en == 4'b0000), "idle_pins", {27'd0, sck, dout_en}, 32'd0);
            if (!p_ce_n) begin
               chk(r == N, "sck_edges", 32'(r), 32'(N));
               chk(p_sck && (run == D), "last_high", 32'(run), 32'(D));
               hi_run = 0;
            end
            hi_run++;
            r   = 0;
            din = 4'($urandom);
         end else begin
            if (p_ce_n) begin
               chk((hi_run >= GAPC) && (sck == 1'b0), "ce_high_time", 32'(hi_run), 32'(GAPC));
               run = 1;
            end else if (sck != p_sck) begin
               chk(run == D, "sck_half_period", 32'(run), 32'(D));
               run = 1;
               if (sck) begin
                  chk((dout == p_dout) && (dout_en == p_dout_en), "dout_stable_at_rise",
                      {24'd0, dout_en, dout}, {24'd0, p_dout_en, p_dout});
                  if (r < 32) ca = {ca[30:0], dout[0]};
                  r++;
                  if (r == 32) begin
                     flash_addr = ca[23:0];
                     chk(ca[31:24] == 8'h6B, "opcode", 32'(ca[31:24]), 32'h6B);
                     if (exp_q.size() != 0)
                        chk(ca[23:0] == exp_q[0].addr, "address", 32'(ca[23:0]), 32'(exp_q[0].addr));
                  end
               end else if ((r >= 32 + DUMMY) && (r < N)) begin
                  j   = r - 32 - DUMMY;
                  b   = flash_byte(flash_addr + 24'(j / 2));
                  din = ((j % 2) == 0) ? b[7:4] : b[3:0];
               end
            end else begin
               run++;
            end

            if ((r < 32) || ((r == 32) && sck))
               chk((dout_en == 4'b1101) && (dout[3:1] == 3'b110), "cmd_addr_pins",
                   {24'd0, dout_en, dout}, {24'd0, 4'b1101, 3'b110, dout[0]});
            else
               chk(dout_en == 4'b0000, "quiet_pins", 32'(dout_en), 32'd0);
         end
      end
      p_sck     = sck;
      p_ce_n    = ce_n;
      p_dout    = dout;
      p_dout_en = dout_en;
   end

   // ---------------------------------------------------------------- stimulus
   // Called just after a rising edge; returns just after the accepting edge
   task automatic issue(input logic [23:0] a, input bit hold);
      int unsigned waited = 0;
      logic [23:0] base;
      exp_t        e;
      bus.req  = 1'b1;
      bus.addr = a;
      do begin
         @(negedge clk);
         waited++;
      end while (!bus.gnt && (waited < 2000));
      if (bus.gnt) begin
         base   = a & 24'hFF_FFFC;
         e.addr = base;
         e.word = {flash_byte(base + 24'd3), flash_byte(base + 24'd2),
                   flash_byte(base + 24'd1), flash_byte(base)};
         e.due  = cyc + LAT;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!hold) bus.req = 1'b0;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while ((exp_q.size() != 0) && (n < 4 * LAT)) begin
         @(posedge clk);
         n++;
      end
      repeat (GAPC + 2) @(posedge clk);
      #1;
   endtask

   initial begin
      mem[32'h100] = 8'h11;
      mem[32'h101] = 8'h22;
      mem[32'h102] = 8'h33;
      mem[32'h103] = 8'h44;
      rst_ni   = 1'b0;
      bus.req  = 1'b1;
      bus.addr = 24'h000103;
      repeat (4) @(posedge clk);
      #1;
      rst_ni  = 1'b1;
      bus.req = 1'b0;
      @(posedge clk);
      #1;

      // Basic read: expect 32'h44332211
      issue(24'h000103, 1'b0);
      drain();

      // Back-to-back with req held high
      issue(24'h000010, 1'b1);
      issue(24'h000020, 1'b0);
      drain();

      // Random addresses, random idle gaps, random back-to-back
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         issue(24'($urandom), 1'($urandom_range(0, 1)));
      end
      bus.req = 1'b0;
      drain();

      // Abort in the middle of the data phase, then a fresh read
      issue(24'h000200, 1'b0);
      repeat (2 * D * (32 + DUMMY + 3)) @(posedge clk);
      #1;
      rst_ni = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
      issue(24'h000103, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
